key_event_ctrl: RTL and testbench
=================================

# key_event_ctrl

Front-end controller for the game's push-buttons. It synchronizes and debounces `N_KEYS` raw button inputs on a shared slow sampling tick, and turns presses into single key events. Held direction keys generate auto-repeat events. Events from all keys are arbitrated into a small FIFO, which the game FSM drains through a valid/ready handshake.

## Interface
- `N_KEYS`, 5: number of buttons; index 0-3 = up/down/left/right, 4 = place stone.
- `TICK_DIV`, 100000: sampling tick period in `clk` cycles; must be ≥ `N_KEYS`.
- `STABLE_CNT`, 5: number of consecutive differing tick samples needed to flip a debounced level; must be ≥ 2.
- `REPEAT_MASK`, 5'b01111: keys that auto-repeat.
- `REPEAT_DLY`, 50: ticks from press to the first repeat.
- `REPEAT_RATE`, 10: ticks between subsequent repeats.
- `FIFO_DEPTH`, 4: event FIFO entries; power of 2.
- `clk`, in, 1: system clock.
- `rst`, in, 1: synchronous, active-high reset.
- `key_raw`, in, N_KEYS: raw active-high buttons, asynchronous to `clk`.
- `key_level`, out, N_KEYS: debounced levels.
- `ev_valid`, out, 1: FIFO head holds an event.
- `ev_code`, out, CW = clog2(N_KEYS): key index of the head event.
- `ev_repeat`, out, 1: head event is an auto-repeat, not a fresh press.
- `ev_ready`, in, 1: consumer accepts the head event.
- `ev_drop`, out, 1: sticky flag; at least one event was lost.

## Operation
- **Synchronizer:** 2-flop synchronizer per key; all logic below uses the synchronized bit `s[i]`.
- **Tick generator:** counter runs 0..TICK_DIV-1. `tick` is high for the one cycle where the count equals TICK_DIV-1, then the counter wraps to 0.
- **Debounce (per key, tick cycles only):**
  - If `s[i] == key_level[i]`, clear `dcnt[i]`.
  - Otherwise increment `dcnt[i]`.
  - When the sample that makes the count reach `STABLE_CNT` is taken, toggle `key_level[i]` and clear `dcnt[i]`.
  - Any agreeing sample restarts the count, so chatter shorter than `STABLE_CNT` ticks never changes the level.
- **Press event:** a 0→1 transition of `key_level[i]` sets `pend[i]=1`, `prep[i]=0`, and clears `hold[i]`.
- **Release:** a 1→0 transition produces no event and stops `hold[i]`.
- **Auto-repeat:** applies only while `key_level[i]=1` and `REPEAT_MASK[i]=1`.
  - `hold[i]` increments each tick.
  - When it reaches `REPEAT_DLY`, set `pend[i]=1`, `prep[i]=1`, and load `hold[i]=REPEAT_DLY-REPEAT_RATE`. This yields the first repeat after `REPEAT_DLY` ticks and later repeats every `REPEAT_RATE` ticks.
  - `hold[i]` saturates; it never wraps.
- **Pending collision:** a new event for key i while `pend[i]` is still set is dropped, and `ev_drop` is set to 1. The existing pending event is kept unchanged.
- **Scheduler:**
  - Each cycle, the lowest-index set `pend[i]` is pushed as `{i, prep[i]}` into the FIFO, provided the FIFO is not full or a pop occurs in the same cycle. Its `pend[i]` is then cleared.
  - At most one push per cycle.
  - While the FIFO is full with no pop, pending events are held, not lost.
- **FIFO:** circular buffer with read/write pointers and an occupancy count.
  - `ev_valid = (count != 0)`; `ev_code`/`ev_repeat` show the head entry.
  - Pop on `ev_valid && ev_ready`.
  - Push and pop in the same cycle leave the count unchanged, including when the FIFO is full.
  - No bypass: an empty FIFO shows a pushed entry one cycle later.
  - Pointers wrap modulo `FIFO_DEPTH`.
- **Handshake rule:** while `ev_valid=1` and `ev_ready=0`, `ev_code` and `ev_repeat` hold stable.

## Timing
- **Reset values:** `key_level=0`, `ev_valid=0`, `ev_code=0`, `ev_repeat=0`, `ev_drop=0`. All internal state is cleared: tick counter, `dcnt`, `hold`, `pend`, FIFO pointers and count.
- **Reset mid-operation:** FIFO contents and pending events are discarded; `ev_valid` is 0 from the first edge with `rst=1`. A key held through reset re-debounces from level 0 and yields one fresh press event after `STABLE_CNT` ticks.
- **Input to level:** `key_raw` edge → `s` after 2 cycles → `key_level` updates at the clock edge of the `STABLE_CNT`-th differing tick sample.
- **Level to event:** `pend` is set at the same edge as `key_level` rises. The push happens at the next edge, so `ev_valid` rises 1 cycle after `key_level`. Each additional simultaneous key adds 1 cycle.
- **Simultaneous events:** all pending events drain within `N_KEYS` cycles, which is before the next tick, unless the FIFO is full.
- **Pop:** `ev_ready` is sampled at the edge; the next entry, or `ev_valid=0`, appears after that edge.

## Test plan
Run with `TICK_DIV=4`, `STABLE_CNT=3`, `REPEAT_DLY=4`, `REPEAT_RATE=2`, `FIFO_DEPTH=4`.
1. **Clean press:** hold `key_raw[2]` high for 40 cycles, `ev_ready=1` → `key_level[2]` rises at the 3rd tick after sync. Exactly one event: code 2, repeat 0, one cycle after the level rises. The release produces no event.
2. **Chatter:** toggle `key_raw[0]` every 4 cycles for 80 cycles → `key_level[0]` stays 0, no `ev_valid`, `ev_drop=0`.
3. **Simultaneous press:** raise keys 3 and 1 in the same cycle → two consecutive pushes in order code 1, then code 3, both with repeat 0.
4. **Auto-repeat and mask:**
   - Hold key 0 for 12 ticks → press event, then repeats after 4, 6, 8, 10 and 12 ticks from the press (5 repeats).
   - Hold key 4 for 12 ticks → exactly one event.
5. **Backpressure:**
   - With `ev_ready=0`, press keys 0-4 once → FIFO holds codes 0-3; key 4 stays pending; the head stays stable.
   - Re-press key 4 before the drain → `ev_drop=1`.
   - Set `ev_ready=1` → codes 0, 1, 2, 3, 4 are delivered, one per cycle.
6. **Reset mid-operation:** with 2 entries queued and key 1 held, pulse `rst` for 1 cycle → all outputs are 0 after the edge. Later, one fresh code-1 press event appears.

Source files
------------

// File: rtl/key_event_ctrl.sv
// key_event_ctrl: push-button front end for the game controller.
//   Synchronizes and debounces N_KEYS raw buttons on a slow sampling tick, turns
//   presses (and auto-repeat of held keys in REPEAT_MASK) into key events, and
//   queues them in a small FIFO drained through a valid/ready handshake.
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   key_raw    raw active-high buttons, asynchronous to clk
//   key_level  debounced key levels
//   ev_valid   FIFO head holds an event
//   ev_code    key index of the head event
//   ev_repeat  head event is an auto-repeat rather than a fresh press
//   ev_ready   consumer accepts the head event
//   ev_drop    sticky: at least one event was lost to a pending collision
module key_event_ctrl #(
    parameter int unsigned N_KEYS      = 5,
    parameter int unsigned TICK_DIV    = 100000,
    parameter int unsigned STABLE_CNT  = 5,
    parameter logic [N_KEYS-1:0] REPEAT_MASK = N_KEYS'(5'b01111),
    parameter int unsigned REPEAT_DLY  = 50,
    parameter int unsigned REPEAT_RATE = 10,
    parameter int unsigned FIFO_DEPTH  = 4,
    localparam int unsigned CW = (N_KEYS > 1) ? $clog2(N_KEYS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_raw,
    output logic [N_KEYS-1:0] key_level,
    output logic              ev_valid,
    output logic [CW-1:0]     ev_code,
    output logic              ev_repeat,
    input  logic              ev_ready,
    output logic              ev_drop
);

    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DW = $clog2(STABLE_CNT + 1);
    localparam int unsigned HW = $clog2(REPEAT_DLY + 1);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned NW = $clog2(FIFO_DEPTH + 1);

    logic [N_KEYS-1:0] sync1_q, s_q;
    logic [TW-1:0]     tcnt_q;
    logic              tick;

    logic [N_KEYS-1:0] level_q, level_d;
    logic [DW-1:0]     dcnt_q [N_KEYS];
    logic [DW-1:0]     dcnt_d [N_KEYS];
    logic [HW-1:0]     hold_q [N_KEYS];
    logic [HW-1:0]     hold_d [N_KEYS];
    logic [N_KEYS-1:0] ev_new, ev_rep;

    logic [N_KEYS-1:0] pend_q, pend_d, prep_q, prep_d;
    logic              drop_q, drop_d;

    logic [CW:0]       mem_q [FIFO_DEPTH];
    logic [PW-1:0]     rptr_q, wptr_q;
    logic [NW-1:0]     cnt_q, cnt_d;
    logic              has_pend, sel_rep, push, pop, full;
    logic [CW-1:0]     sel;

    assign tick = (tcnt_q == TW'(TICK_DIV - 1));

    // Debounce, press detection and auto-repeat; everything advances on ticks only.
    always_comb begin
        level_d = level_q;
        ev_new  = '0;
        ev_rep  = '0;
        for (int i = 0; i < int'(N_KEYS); i++) begin
            dcnt_d[i] = dcnt_q[i];
            hold_d[i] = hold_q[i];
            if (tick) begin
                if (s_q[i] == level_q[i]) begin
                    dcnt_d[i] = '0;
                end else if (dcnt_q[i] == DW'(STABLE_CNT - 1)) begin
                    dcnt_d[i]  = '0;
                    level_d[i] = ~level_q[i];
                end else begin
                    dcnt_d[i] = dcnt_q[i] + 1'b1;
                end

                if (!level_q[i] && level_d[i]) begin
                    ev_new[i] = 1'b1;
                    hold_d[i] = '0;
                end else if (level_q[i] && !level_d[i]) begin
                    hold_d[i] = '0;
                end else if (level_q[i] && REPEAT_MASK[i]) begin
                    if (hold_q[i] == HW'(REPEAT_DLY - 1)) begin
                        // Reload so the next repeat comes REPEAT_RATE ticks later.
                        ev_new[i] = 1'b1;
                        ev_rep[i] = 1'b1;
                        hold_d[i] = HW'(REPEAT_DLY - REPEAT_RATE);
                    end else if (hold_q[i] < HW'(REPEAT_DLY)) begin
                        hold_d[i] = hold_q[i] + 1'b1;
                    end
                end
            end
        end
    end

    // Lowest-index pending key wins the single push slot.
    always_comb begin
        has_pend = 1'b0;
        sel      = '0;
        sel_rep  = 1'b0;
        for (int i = int'(N_KEYS) - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                has_pend = 1'b1;
                sel      = CW'(i);
                sel_rep  = prep_q[i];
            end
        end
    end

    assign full = (cnt_q == NW'(FIFO_DEPTH));
    assign pop  = (cnt_q != '0) && ev_ready;
    assign push = has_pend && (!full || pop);

    // A slot freed by this cycle's push may take a new event in the same cycle.
    always_comb begin
        pend_d = pend_q;
        prep_d = prep_q;
        drop_d = drop_q;
        for (int i = 0; i < int'(N_KEYS); i++) begin
            if (push && sel == CW'(i)) begin
                pend_d[i] = 1'b0;
            end
            if (ev_new[i]) begin
                if (pend_d[i]) begin
                    drop_d = 1'b1;
                end else begin
                    pend_d[i] = 1'b1;
                    prep_d[i] = ev_rep[i];
                end
            end
        end
    end

    always_comb begin
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            s_q     <= '0;
            tcnt_q  <= '0;
            level_q <= '0;
            pend_q  <= '0;
            prep_q  <= '0;
            drop_q  <= 1'b0;
            rptr_q  <= '0;
            wptr_q  <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < int'(N_KEYS); i++) begin
                dcnt_q[i] <= '0;
                hold_q[i] <= '0;
            end
        end else begin
            sync1_q <= key_raw;
            s_q     <= sync1_q;
            tcnt_q  <= tick ? '0 : tcnt_q + 1'b1;
            level_q <= level_d;
            pend_q  <= pend_d;
            prep_q  <= prep_d;
            drop_q  <= drop_d;
            cnt_q   <= cnt_d;
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            for (int i = 0; i < int'(N_KEYS); i++) begin
                dcnt_q[i] <= dcnt_d[i];
                hold_q[i] <= hold_d[i];
            end
        end
    end

    // Storage needs no reset: outputs are gated by the occupancy count.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wptr_q] <= {sel, sel_rep};
        end
    end

    assign key_level = level_q;
    assign ev_valid  = (cnt_q != '0);
    assign ev_code   = ev_valid ? mem_q[rptr_q][CW:1] : '0;
    assign ev_repeat = ev_valid ? mem_q[rptr_q][0] : 1'b0;
    assign ev_drop   = drop_q;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Scoreboard bench for key_event_ctrl: stimulus pushes expected {code, repeat}
// entries, a negedge monitor pops and compares on every accepted event.
module tb_key_event_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] key_raw;
    logic [4:0] key_level;
    logic       ev_valid;
    logic [2:0] ev_code;
    logic       ev_repeat;
    logic       ev_ready;
    logic       ev_drop;

    int n_checks = 0;
    int n_pass   = 0;
    logic [3:0] exp_q[$];

    key_event_ctrl #(
        .N_KEYS      (5),
        .TICK_DIV    (4),
        .STABLE_CNT  (3),
        .REPEAT_MASK (5'b01111),
        .REPEAT_DLY  (4),
        .REPEAT_RATE (2),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_raw   (key_raw),
        .key_level (key_level),
        .ev_valid  (ev_valid),
        .ev_code   (ev_code),
        .ev_repeat (ev_repeat),
        .ev_ready  (ev_ready),
        .ev_drop   (ev_drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic expect_ev(input int code, input int rep);
        logic [3:0] e;
        e[3:1] = code[2:0];
        e[0]   = rep[0];
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Bounded wait at negedges for key_level[idx] == val; n = negedges consumed.
    task automatic wait_level(input int idx, input logic val, input int maxc,
                              input string name, output int n);
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (key_level[idx] == val || n >= maxc) break;
        end
        if (key_level[idx] != val) check({name, "_timeout"}, int'(key_level[idx]), int'(val));
    endtask

    // Monitor: scoreboard pop on each handshake, head stability while stalled.
    initial begin
        logic [3:0] e;
        logic [3:0] held;
        logic       stalled;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (!rst && ev_valid && ev_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL ev_unexpected: got code %0d repeat %0d, expected no event",
                             ev_code, ev_repeat);
                end else begin
                    e = exp_q.pop_front();
                    check("ev_code", int'(ev_code), int'(e[3:1]));
                    check("ev_repeat", int'(ev_repeat), int'(e[0]));
                end
            end
            if (stalled && ev_valid && !rst) begin
                check("stall_code", int'(ev_code), int'(held[3:1]));
                check("stall_repeat", int'(ev_repeat), int'(held[0]));
            end
            stalled = ev_valid && !ev_ready && !rst;
            held    = {ev_code, ev_repeat};
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        int   n;
        logic lvl_seen;

        rst      = 1'b1;
        key_raw  = '0;
        ev_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_level", int'(key_level), 0);
        check("rst_valid", int'(ev_valid), 0);
        check("rst_code", int'(ev_code), 0);
        check("rst_repeat", int'(ev_repeat), 0);
        check("rst_drop", int'(ev_drop), 0);
        step();
        rst = 1'b0;

        // 1: clean press of key 2, released before any repeat.
        expect_ev(2, 0);
        step();
        key_raw[2] = 1'b1;
        wait_level(2, 1'b1, 40, "t1_rise", n);
        check("t1_latency_in_window", int'(n >= 12 && n <= 15), 1);
        check("t1_valid_same_cycle", int'(ev_valid), 0);
        step();
        key_raw[2] = 1'b0;
        @(negedge clk);
        check("t1_valid_next_cycle", int'(ev_valid), 1);
        check("t1_code_next_cycle", int'(ev_code), 2);
        wait_level(2, 1'b0, 40, "t1_fall", n);
        repeat (20) @(negedge clk);
        check("t1_drained", exp_q.size(), 0);

        // 2: chatter on key 0, every tick sample disagrees with the previous one.
        lvl_seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            key_raw[0] = ~key_raw[0];
            for (int j = 0; j < 4; j++) begin
                @(negedge clk);
                if (key_level[0]) lvl_seen = 1'b1;
            end
        end
        repeat (20) @(negedge clk);
        check("t2_level_never_high", int'(lvl_seen), 0);
        check("t2_drop", int'(ev_drop), 0);

        // 3: keys 3 and 1 pressed together, lower index first.
        expect_ev(1, 0);
        expect_ev(3, 0);
        step();
        key_raw[1] = 1'b1;
        key_raw[3] = 1'b1;
        wait_level(1, 1'b1, 40, "t3_rise", n);
        check("t3_level3_same_tick", int'(key_level[3]), 1);
        step();
        key_raw[1] = 1'b0;
        key_raw[3] = 1'b0;
        wait_level(3, 1'b0, 40, "t3_fall", n);
        repeat (10) @(negedge clk);
        check("t3_drained", exp_q.size(), 0);

        // 4a: key 0 held 12 ticks: press then repeats at ticks 4, 6, 8, 10, 12.
        expect_ev(0, 0);
        for (int k = 0; k < 5; k++) expect_ev(0, 1);
        step();
        key_raw[0] = 1'b1;
        wait_level(0, 1'b1, 40, "t4a_rise", n);
        repeat (40) @(posedge clk);
        #2;
        key_raw[0] = 1'b0;
        wait_level(0, 1'b0, 60, "t4a_fall", n);
        repeat (10) @(negedge clk);
        check("t4a_repeat_count", exp_q.size(), 0);

        // 4b: key 4 is not in the repeat mask.
        expect_ev(4, 0);
        step();
        key_raw[4] = 1'b1;
        wait_level(4, 1'b1, 40, "t4b_rise", n);
        repeat (40) @(posedge clk);
        #2;
        key_raw[4] = 1'b0;
        wait_level(4, 1'b0, 60, "t4b_fall", n);
        repeat (10) @(negedge clk);
        check("t4b_single_event", exp_q.size(), 0);

        // 5: backpressure, key 4 left pending, then a colliding re-press of key 4.
        for (int k = 0; k < 5; k++) expect_ev(k, 0);
        step();
        ev_ready = 1'b0;
        key_raw  = 5'b11111;
        wait_level(0, 1'b1, 40, "t5_rise", n);
        step();
        key_raw = '0;
        repeat (6) @(negedge clk);
        check("t5_valid_full", int'(ev_valid), 1);
        check("t5_head_code", int'(ev_code), 0);
        wait_level(4, 1'b0, 40, "t5_fall", n);
        check("t5_drop_before", int'(ev_drop), 0);
        step();
        key_raw[4] = 1'b1;
        wait_level(4, 1'b1, 40, "t5_rerise", n);
        check("t5_drop_after", int'(ev_drop), 1);
        step();
        key_raw[4] = 1'b0;
        wait_level(4, 1'b0, 40, "t5_refall", n);
        step();
        ev_ready = 1'b1;
        repeat (6) @(negedge clk);
        check("t5_drained_in_5", int'(ev_valid), 0);
        check("t5_all_delivered", exp_q.size(), 0);

        // 6: reset with queued press+repeat of held key 1, then one fresh press.
        step();
        ev_ready   = 1'b0;
        key_raw[1] = 1'b1;
        wait_level(1, 1'b1, 40, "t6_rise", n);
        repeat (20) @(negedge clk);
        check("t6_queued_valid", int'(ev_valid), 1);
        check("t6_queued_code", int'(ev_code), 1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("t6_rst_level", int'(key_level), 0);
        check("t6_rst_valid", int'(ev_valid), 0);
        check("t6_rst_code", int'(ev_code), 0);
        check("t6_rst_repeat", int'(ev_repeat), 0);
        check("t6_rst_drop", int'(ev_drop), 0);
        expect_ev(1, 0);
        ev_ready = 1'b1;
        wait_level(1, 1'b1, 40, "t6_rerise", n);
        step();
        key_raw[1] = 1'b0;
        wait_level(1, 1'b0, 40, "t6_fall", n);
        repeat (10) @(negedge clk);
        check("t6_fresh_press", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
